deconv_serial: RTL

//   Inverse of the linear-convolution datapath: recovers input x[n] from convolved stream y[n] for known monic FIR h (h[0]==1).

---
 rtl/conv_pkg.sv | 32 +++
 rtl/deconv_mac.sv | 42 ++++
 rtl/deconv_serial.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution / deconvolution datapaths.
package conv_pkg;

  localparam int unsigned DefW    = 8;
  localparam int unsigned DefTaps = 4;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StOut
  } state_e;

  // Clamp v into the signed range of a w-bit value; clamped reports whether it moved.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned       w,
                                                   output logic             clamped);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    clamped = 1'b1;
    if (v > hi) begin
      sat_clamp = hi;
    end else if (v < lo) begin
      sat_clamp = lo;
    end else begin
      sat_clamp = v;
      clamped   = 1'b0;
    end
  endfunction

endpackage

// File: rtl/deconv_mac.sv
// Serial multiply-subtract unit: acc is either loaded with a sign-extended sample or
// decremented by one signed W x W product per enabled cycle.
module deconv_mac #(
  parameter int unsigned W     = 8,
  parameter int unsigned ACC_W = 19
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic signed [W-1:0]     load_data_i,
  input  logic                    en_i,
  input  logic signed [W-1:0]     coef_i,
  input  logic signed [W-1:0]     sample_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] acc_d, acc_q;

  assign prod  = coef_i * sample_i;
  assign acc_o = acc_q;

  // Next accumulator value: load has priority over a MAC step.
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = {{(ACC_W - W){load_data_i[W-1]}}, load_data_i};
    end else if (en_i) begin
      acc_d = acc_q - {{(ACC_W - 2 * W){prod[2*W-1]}}, prod};
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/deconv_serial.sv
// Serial deconvolver for a monic FIR: x[n] = y[n] - sum h[k]*x[n-k], one MAC per cycle.
// Build option DECONV_SAT_EN: clamp the result to W bits and expose out_sat_o;
// otherwise the result wraps.
module deconv_serial
  import conv_pkg::*;
#(
  parameter int unsigned W     = DefW,
  parameter int unsigned TAPS  = DefTaps,
  parameter int unsigned ACC_W = 2 * W + $clog2(TAPS) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                coef_we_i,
  input  logic [3:0]          coef_addr_i,
  input  logic signed [W-1:0] coef_data_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic signed [W-1:0] in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic signed [W-1:0] out_data_o
`ifdef DECONV_SAT_EN
  ,
  output logic                out_sat_o
`endif
);

  localparam int unsigned KW = $clog2(TAPS);

  state_e                  state_d, state_q;
  logic [KW-1:0]           k_d, k_q;
  logic                    out_valid_d, out_valid_q;
  logic signed [W-1:0]     out_data_d, out_data_q;
  logic signed [W-1:0]     h_q    [1:TAPS-1];
  logic signed [W-1:0]     hist_q [0:TAPS-2];
  logic signed [W-1:0]     coef_sel, hist_sel, result;
  logic signed [ACC_W-1:0] acc;
  logic                    accept, idle, hist_shift, result_sat;

  assign idle        = (state_q == StIdle);
  assign in_ready_o  = idle && !clear_i;
  assign accept      = in_valid_i && in_ready_o;
  assign hist_shift  = (state_q == StOut) && out_valid_q && out_ready_i;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  // Select h[k] and x[n-k] for the current MAC step.
  always_comb begin
    coef_sel = '0;
    hist_sel = '0;
    for (int unsigned i = 1; i < TAPS; i++) begin
      if (k_q == KW'(i)) begin
        coef_sel = h_q[i];
        hist_sel = hist_q[i-1];
      end
    end
  end

  deconv_mac #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (accept),
    .load_data_i (in_data_i),
    .en_i        (state_q == StMac),
    .coef_i      (coef_sel),
    .sample_i    (hist_sel),
    .acc_o       (acc)
  );

`ifdef DECONV_SAT_EN
  logic signed [63:0] acc_clamped;
  logic               unused_clamp_hi;
  logic               sat_d, sat_q;

  // Clamp the accumulator into W bits.
  always_comb begin
    acc_clamped = sat_clamp(64'(acc), W, result_sat);
  end
  assign result          = acc_clamped[W-1:0];
  assign unused_clamp_hi = ^acc_clamped[63:W];
  assign out_sat_o       = sat_q;
`else
  logic unused_acc_hi;
  assign result        = acc[W-1:0];
  assign result_sat    = 1'b0;
  assign unused_acc_hi = ^{acc[ACC_W-1:W], result_sat};
`endif

  // FSM next state and output register next values.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef DECONV_SAT_EN
    sat_d       = sat_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          k_d     = KW'(1);
          state_d = StMac;
        end
      end
      StMac: begin
        if (k_q == KW'(TAPS - 1)) begin
          state_d = StOut;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StOut: begin
        // First OUT cycle captures the result; it then holds until accepted.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = result;
`ifdef DECONV_SAT_EN
          sat_d       = result_sat;
`endif
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef DECONV_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef DECONV_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  // Coefficient regfile h[1..TAPS-1]; writes only land while idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 1; i < TAPS; i++) h_q[i] <= '0;
    end else if (idle && coef_we_i) begin
      for (int unsigned i = 1; i < TAPS; i++) begin
        if (32'(coef_addr_i) == i) h_q[i] <= coef_data_i;
      end
    end
  end

  // History of emitted samples, newest in slot 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < TAPS - 1; i++) hist_q[i] <= '0;
    end else if (idle && clear_i) begin
      for (int unsigned i = 0; i < TAPS - 1; i++) hist_q[i] <= '0;
    end else if (hist_shift) begin
      hist_q[0] <= out_data_q;
      for (int unsigned i = 1; i < TAPS - 1; i++) hist_q[i] <= hist_q[i-1];
    end
  end

endmodule
